vending_machine_param: RTL
==========================

Name: vending_machine_param

Overview:
- Parametrised successor to the single-price nickel/dime/quarter vending FSM.
- Adds: two products with independent prices, a binary credit accumulator, an overflow coin reject, cancel/refund, and greedy change dispensing over a ready handshake.
- Sits between the coin acceptor, the product buttons and the change hopper.
- All money is counted in nickel units: nickel = 1, dime = 2, quarter = 5.

Parameters:
- CREDIT_W, 6, width of the credit register in nickel units.
- PRICE_A, 4, price of product A in nickel units (20c). Must satisfy 1 ≤ PRICE_A ≤ MAX_CREDIT.
- PRICE_B, 7, price of product B in nickel units (35c). Must satisfy 1 ≤ PRICE_B ≤ MAX_CREDIT.
- MAX_CREDIT, 12, largest credit held (60c). Must be < 2^CREDIT_W.

Ports:
- clk  in  1  clock.
- rs  in  1  reset, asynchronous, active-high.
- nickle  in  1  nickel-inserted pulse, 1 cycle.
- dime  in  1  dime-inserted pulse.
- quarter  in  1  quarter-inserted pulse.
- sel_a  in  1  product A request pulse.
- sel_b  in  1  product B request pulse.
- cancel  in  1  refund request pulse.
- chg_ready  in  1  hopper accepts the presented change coin this cycle.
- s  out  1  vend strobe, 1 cycle.
- prod  out  1  product vended (0 = A, 1 = B); valid while s = 1.
- credit  out  CREDIT_W  current credit in nickel units.
- chg_nickle  out  1  change coin presented: nickel.
- chg_dime  out  1  change coin presented: dime.
- chg_quarter  out  1  change coin presented: quarter.
- coin_reject  out  1  returned-coin pulse, 1 cycle.
- deny  out  1  selection refused for insufficient credit, 1 cycle.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset, asynchronous on rs high: state IDLE, credit 0, all outputs 0. Applies immediately in any state; a coin pending in CHANGE is abandoned and credit is cleared.
- States: IDLE, VEND, CHANGE.
- IDLE, per cycle, priority cancel > selection > coin:
  - cancel with credit > 0: go to CHANGE. cancel with credit = 0: no effect.
  - sel_a and sel_b together: treat as sel_a.
  - Selection with credit ≥ its price: latch prod, go to VEND.
  - Selection with credit < price: deny = 1 next cycle, stay in IDLE, credit unchanged.
  - Coin on a cycle that also carries cancel or a selection: rejected (coin_reject next cycle), no credit added.
  - More than one coin input high in one cycle: reject, no credit.
  - Single coin: compute sum = credit + value in CREDIT_W+1 bits.
    - sum ≤ MAX_CREDIT: credit = sum, visible next cycle.
    - sum > MAX_CREDIT: coin_reject next cycle, credit unchanged.
- VEND, exactly 1 cycle:
  - s = 1 with prod valid.
  - credit decrements by the selected price at the end of the cycle.
  - Next state is CHANGE if remaining credit > 0, else IDLE.
  - Latency: selection in cycle t gives s high in cycle t+1.
- CHANGE: greedy dispensing, one coin presented at a time, chosen from current credit:
  - credit ≥ 5: chg_quarter.
  - otherwise credit ≥ 2: chg_dime.
  - otherwise: chg_nickle.
  - Exactly one chg_* is high throughout CHANGE; the presented coin stays stable until chg_ready = 1.
  - On a chg_ready = 1 cycle, credit decrements by the coin value at clock end.
  - When the new credit is 0, go to IDLE with all chg_* low the next cycle.
  - chg_ready low stalls indefinitely with no state change.
- Coins, selections and cancel during VEND or CHANGE:
  - Coins: coin_reject next cycle.
  - Selections and cancel: ignored, no deny.
- Outputs are registered from state/credit: s, prod, coin_reject and deny are 1-cycle registered pulses; chg_* and busy are Moore outputs of state and credit.
- credit never exceeds MAX_CREDIT and never underflows. Arithmetic is unsigned.

Test Plan:
- Reset mid-CHANGE with credit 3 and chg_ready = 0, rs pulsed → all outputs 0 and credit 0 immediately. After release, chg_* stay low.
- quarter, then dime, then sel_a (defaults) → credit 5, then 7. s = 1, prod = 0 at sel+1; credit 3. CHANGE presents chg_dime, then chg_nickle (chg_ready = 1). Returns to IDLE with credit 0, total 4 cycles from sel.
- dime, then sel_b → deny pulse, credit stays 2, no s. Then quarter, then sel_b → s = 1, prod = 1, credit 0, IDLE next cycle, no chg_*.
- 2 quarters (credit 10), then a quarter → coin_reject, credit 10. Then dime → credit 12. Then nickel → coin_reject.
- Credit 8, cancel, chg_ready held 0 for 3 cycles → chg_quarter held stable, credit 8. Raise chg_ready → quarter, dime, nickel over 3 cycles; credit 3, 1, 0. A dime inserted mid-change → coin_reject.
- Simultaneous nickle + dime → coin_reject. sel_a + nickle with credit 4 → vend A, nickel rejected, credit 0.

Source files
------------

// File: rtl/vending_machine_param.sv
// Two-product vending controller with credit accumulation and greedy change return.
// All money is counted in nickel units (nickel = 1, dime = 2, quarter = 5).
//
// Ports:
//   clk, rs            clock, asynchronous active-high reset
//   nickle/dime/quarter coin-inserted pulses
//   sel_a, sel_b        product request pulses (A wins if both are high)
//   cancel              refund request pulse
//   chg_ready           hopper accepts the presented change coin this cycle
//   s, prod             vend strobe and vended product (0 = A, 1 = B)
//   credit              current credit
//   chg_nickle/dime/quarter  presented change coin (one-hot while refunding)
//   coin_reject, deny   1-cycle pulses: coin returned / selection refused
//   busy                high while vending or returning change
module vending_machine_param #(
    parameter int unsigned CREDIT_W   = 6,
    parameter int unsigned PRICE_A    = 4,
    parameter int unsigned PRICE_B    = 7,
    parameter int unsigned MAX_CREDIT = 12
) (
    input  logic                clk,
    input  logic                rs,
    input  logic                nickle,
    input  logic                dime,
    input  logic                quarter,
    input  logic                sel_a,
    input  logic                sel_b,
    input  logic                cancel,
    input  logic                chg_ready,
    output logic                s,
    output logic                prod,
    output logic [CREDIT_W-1:0] credit,
    output logic                chg_nickle,
    output logic                chg_dime,
    output logic                chg_quarter,
    output logic                coin_reject,
    output logic                deny,
    output logic                busy
);

    typedef enum logic [1:0] {StIdle, StVend, StChange} state_e;

    localparam logic [CREDIT_W-1:0] PriceA  = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] PriceB  = CREDIT_W'(PRICE_B);
    localparam logic [CREDIT_W:0]   MaxSum  = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] CredZero = '0;
    localparam logic [CREDIT_W-1:0] CredTwo  = CREDIT_W'(2);
    localparam logic [CREDIT_W-1:0] CredFive = CREDIT_W'(5);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                prod_q, prod_d;
    logic                s_q, s_d;
    logic                rej_q, rej_d;
    logic                deny_q, deny_d;

    logic                coin_any;
    logic                coin_multi;
    logic [2:0]          coin_val;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] vend_price;
    logic [CREDIT_W-1:0] chg_val;

    always_comb begin
        coin_any   = nickle | dime | quarter;
        coin_multi = (nickle & dime) | (nickle & quarter) | (dime & quarter);
        coin_val   = nickle ? 3'd1 : (dime ? 3'd2 : 3'd5);
        // One extra bit so an overflowing coin is detected rather than wrapped.
        sum        = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_val);
        sel_price  = sel_a ? PriceA : PriceB;
        vend_price = prod_q ? PriceB : PriceA;
        // Greedy coin choice: largest coin not exceeding the remaining credit.
        if (credit_q >= CredFive) begin
            chg_val = CredFive;
        end else if (credit_q >= CredTwo) begin
            chg_val = CredTwo;
        end else begin
            chg_val = CREDIT_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        prod_d   = prod_q;
        s_d      = 1'b0;
        rej_d    = 1'b0;
        deny_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cancel) begin
                    if (credit_q != CredZero) begin
                        state_d = StChange;
                    end
                    rej_d = coin_any;
                end else if (sel_a || sel_b) begin
                    if (credit_q >= sel_price) begin
                        state_d = StVend;
                        prod_d  = ~sel_a;
                        s_d     = 1'b1;
                    end else begin
                        deny_d = 1'b1;
                    end
                    rej_d = coin_any;
                end else if (coin_any) begin
                    if (coin_multi || (sum > MaxSum)) begin
                        rej_d = 1'b1;
                    end else begin
                        credit_d = sum[CREDIT_W-1:0];
                    end
                end
            end
            StVend: begin
                credit_d = credit_q - vend_price;
                state_d  = (credit_d != CredZero) ? StChange : StIdle;
                rej_d    = coin_any;
            end
            StChange: begin
                if (chg_ready) begin
                    credit_d = credit_q - chg_val;
                    if (credit_d == CredZero) begin
                        state_d = StIdle;
                    end
                end
                rej_d = coin_any;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state_q  <= StIdle;
            credit_q <= '0;
            prod_q   <= 1'b0;
            s_q      <= 1'b0;
            rej_q    <= 1'b0;
            deny_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            prod_q   <= prod_d;
            s_q      <= s_d;
            rej_q    <= rej_d;
            deny_q   <= deny_d;
        end
    end

    always_comb begin
        s           = s_q;
        prod        = prod_q;
        credit      = credit_q;
        coin_reject = rej_q;
        deny        = deny_q;
        busy        = (state_q != StIdle);
        chg_quarter = (state_q == StChange) && (chg_val == CredFive);
        chg_dime    = (state_q == StChange) && (chg_val == CredTwo);
        chg_nickle  = (state_q == StChange) && (chg_val == CREDIT_W'(1));
    end

endmodule
